// File: rtl/qed_dup_scheduler_if.sv
// Instruction and commit bundle between fetch/decode/commit and the SQED
// duplicate scheduler. The scheduler is the slave; the surrounding core
// (or a bench) drives the master side.
interface qed_dup_scheduler_if;
    logic        exec_dup;
    logic [31:0] in_instr;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_instr;
    logic        out_valid;
    logic        out_ready;
    logic        commit_orig;
    logic        commit_dup;
    logic        dup_phase;
    logic        qed_check;
    logic        err;

    modport slave (
        input  exec_dup, in_instr, in_valid, out_ready, commit_orig, commit_dup,
        output in_ready, out_instr, out_valid, dup_phase, qed_check, err
    );

    modport master (
        output exec_dup, in_instr, in_valid, out_ready, commit_orig, commit_dup,
        input  in_ready, out_instr, out_valid, dup_phase, qed_check, err
    );
endinterface

// File: rtl/qed_dup_scheduler.sv
// SQED original/duplicate scheduler placed in front of decode.
// ORIG passes originals straight through and queues their register-remapped
// duplicates; DUP replays the queue; DONE drains with NOPs forever. Commit
// counters decide when both halves have retired equally (qed_check).
module qed_dup_scheduler #(
    parameter int          DEPTH     = 16,
    parameter int          AW        = 4,
    parameter int          CNT_W     = 8,
    parameter logic [31:0] NOP_INSTR = 32'h0000007F
) (
    input logic                clk,
    input logic                rst,
    qed_dup_scheduler_if.slave bus
);

    typedef enum logic [1:0] {S_ORIG, S_DUP, S_DONE} state_t;

    localparam logic [AW:0]      DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]      ONE_C   = (AW+1)'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic [CNT_W-1:0] r_n_issued;
    logic [CNT_W-1:0] r_c_orig;
    logic [CNT_W-1:0] r_c_dup;
    logic             r_dup_phase;
    logic             r_qed_check;
    logic             r_err;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [AW:0]      w_count_after;
    logic             w_in_ready;
    logic             w_out_valid;
    logic [31:0]      w_out_instr;
    logic [CNT_W:0]   w_iss_sum;
    logic [CNT_W:0]   w_orig_sum;
    logic [CNT_W:0]   w_dup_sum;
    logic             w_err_evt;

    // Duplicate: move rd/rs1/rs2 from x0-x15 to x16-x31 by setting the MSB of
    // each field the opcode uses; memory ops also shift the offset by +64 so
    // duplicates touch a disjoint memory window.
    function automatic logic [31:0] dup_instr(input logic [31:0] x);
        logic [31:0] m;
        m = '0;
        case (x[6:0])
            7'b0110011: begin m[11] = 1'b1; m[19] = 1'b1; m[24] = 1'b1; end
            7'b0010011: begin m[11] = 1'b1; m[19] = 1'b1; end
            7'b0110111: begin m[11] = 1'b1; end
            7'b1100011: begin m[19] = 1'b1; m[24] = 1'b1; end
            7'b0000011: begin m[11] = 1'b1; m[26] = 1'b1; end
            7'b0100011: begin m[24] = 1'b1; m[26] = 1'b1; end
            default:    m = '0;
        endcase
        return x | m;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        return (inc && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
    endfunction

    assign w_full  = (r_count == DEPTH_C);
    assign w_empty = (r_count == '0);

    // Unsaturated next-cycle totals, used only to detect ordering violations.
    assign w_iss_sum  = {1'b0, r_n_issued} + (CNT_W+1)'(w_push);
    assign w_orig_sum = {1'b0, r_c_orig}   + (CNT_W+1)'(bus.commit_orig);
    assign w_dup_sum  = {1'b0, r_c_dup}    + (CNT_W+1)'(bus.commit_dup);
    assign w_err_evt  = (bus.commit_dup && (r_state == S_ORIG)) ||
                        (w_dup_sum > w_orig_sum) ||
                        (w_orig_sum > w_iss_sum);

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_instr = w_out_instr;
    assign bus.dup_phase = r_dup_phase;
    assign bus.qed_check = r_qed_check;
    assign bus.err       = r_err;

    // Phase outputs, FIFO handshakes and next-state selection.
    always_comb begin
        w_in_ready    = 1'b0;
        w_out_valid   = 1'b0;
        w_out_instr   = '0;
        w_push        = 1'b0;
        w_pop         = 1'b0;
        w_state_nxt   = r_state;
        w_count_after = r_count;
        if (!rst) begin
            case (r_state)
                S_ORIG: begin
                    w_out_instr   = bus.in_instr;
                    w_out_valid   = bus.in_valid;
                    w_in_ready    = bus.out_ready && !w_full;
                    w_push        = bus.in_valid && w_in_ready;
                    w_count_after = r_count + (AW+1)'(w_push);
                    if ((bus.exec_dup && (w_count_after != '0)) || (w_count_after == DEPTH_C)) begin
                        w_state_nxt = S_DUP;
                    end
                end
                S_DUP: begin
                    w_out_valid = !w_empty;
                    w_out_instr = r_mem[r_rptr];
                    w_pop       = w_out_valid && bus.out_ready;
                    if (w_pop && (r_count == ONE_C)) begin
                        w_state_nxt = S_DONE;
                    end
                end
                S_DONE: begin
                    w_out_valid = 1'b1;
                    w_out_instr = NOP_INSTR;
                end
                default: w_state_nxt = S_ORIG;
            endcase
        end
    end

    // Phase register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_ORIG;
        else     r_state <= w_state_nxt;
    end

    // FIFO pointers and occupancy; push and pop never coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr  <= r_wptr + AW'(1);
                r_count <= r_count + ONE_C;
            end
            if (w_pop) begin
                r_rptr  <= r_rptr + AW'(1);
                r_count <= r_count - ONE_C;
            end
        end
    end

    // FIFO storage holds the already-remapped duplicate.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= dup_instr(bus.in_instr);
    end

    // Saturating issue and commit counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_n_issued <= '0;
            r_c_orig   <= '0;
            r_c_dup    <= '0;
        end else begin
            r_n_issued <= sat_inc(r_n_issued, w_push);
            r_c_orig   <= sat_inc(r_c_orig, bus.commit_orig);
            r_c_dup    <= sat_inc(r_c_dup, bus.commit_dup);
        end
    end

    // Registered status: phase flag, check point level and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dup_phase <= 1'b0;
            r_qed_check <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_dup_phase <= (w_state_nxt != S_ORIG);
            r_qed_check <= (r_state == S_DONE) && (r_c_orig == r_n_issued) && (r_c_dup == r_n_issued);
            r_err       <= r_err || w_err_evt;
        end
    end

endmodule

// File: tb/tb_qed_dup_scheduler.sv
// Bench for qed_dup_scheduler: directed scenarios plus randomized rounds
// checked against a field-level duplicate model and a queue scoreboard.
module tb_qed_dup_scheduler;
    localparam int          DEPTH = 16;
    localparam logic [31:0] NOP   = 32'h0000007F;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    qed_dup_scheduler_if bus();

    qed_dup_scheduler #(.DEPTH(16), .AW(4), .CNT_W(8), .NOP_INSTR(32'h0000007F)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference duplicate: registers x0-x15 move up by 16, memory offsets by 64.
    function automatic logic [31:0] model_dup(input logic [31:0] x);
        logic [31:0] y;
        logic [11:0] imm;
        y = x;
        case (x[6:0])
            7'b0110011: begin y[11:7] = x[11:7] + 5'd16; y[19:15] = x[19:15] + 5'd16; y[24:20] = x[24:20] + 5'd16; end
            7'b0010011: begin y[11:7] = x[11:7] + 5'd16; y[19:15] = x[19:15] + 5'd16; end
            7'b0110111: begin y[11:7] = x[11:7] + 5'd16; end
            7'b1100011: begin y[19:15] = x[19:15] + 5'd16; y[24:20] = x[24:20] + 5'd16; end
            7'b0000011: begin y[11:7] = x[11:7] + 5'd16; imm = x[31:20] + 12'd64; y[31:20] = imm; end
            7'b0100011: begin
                y[24:20] = x[24:20] + 5'd16;
                imm = {x[31:25], x[11:7]} + 12'd64;
                y[31:25] = imm[11:5];
                y[11:7]  = imm[4:0];
            end
            default: y = x;
        endcase
        return y;
    endfunction

    // Constrained original: registers in x0-x15, memory offsets with bit 6 clear.
    function automatic logic [31:0] rand_instr();
        logic [31:0] x;
        x = $urandom;
        case ($urandom_range(0, 9))
            0, 1:    x[6:0] = 7'b0110011;
            2:       x[6:0] = 7'b0010011;
            3:       x[6:0] = 7'b0110111;
            4:       x[6:0] = 7'b1100011;
            5:       x[6:0] = 7'b0000011;
            6:       x[6:0] = 7'b0100011;
            7:       x[6:0] = 7'b1101111;
            8:       x[6:0] = 7'b0001111;
            default: x[6:0] = 7'b1110011;
        endcase
        x[11] = 1'b0; x[19] = 1'b0; x[24] = 1'b0; x[26] = 1'b0;
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.exec_dup = 1'b0; bus.in_instr = '0; bus.in_valid = 1'b0;
        bus.out_ready = 1'b0; bus.commit_orig = 1'b0; bus.commit_dup = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b1; bus.in_instr = 32'h002081B3; bus.out_ready = 1'b1;
        bus.exec_dup = 1'b1; bus.commit_dup = 1'b1; bus.commit_orig = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
            n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
            n_cmp++; if (bus.out_instr !== 32'h0) begin n_bad++; $display("FAIL reset_out_instr: got %h want 0", bus.out_instr); end
            n_cmp++; if (bus.dup_phase !== 1'b0) begin n_bad++; $display("FAIL reset_dup_phase: got %b want 0", bus.dup_phase); end
            n_cmp++; if (bus.qed_check !== 1'b0) begin n_bad++; $display("FAIL reset_qed_check: got %b want 0", bus.qed_check); end
            n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus.err); end
        end
        idle();
        rst = 1'b0;
    endtask

    task automatic test_passthrough();
        logic [31:0] add_i;
        do_reset();
        add_i = 32'h002081B3;
        bus.in_instr = add_i; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        #1;
        n_cmp++; if (bus.out_instr !== add_i) begin n_bad++; $display("FAIL pass_instr: got %h want %h", bus.out_instr, add_i); end
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL pass_valid: got %b want 1", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL pass_ready: got %b want 1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0; bus.exec_dup = 1'b1;
        #1;
        n_cmp++; if (bus.dup_phase !== 1'b0) begin n_bad++; $display("FAIL pass_still_orig: got %b want 0", bus.dup_phase); end
        tick();
        bus.exec_dup = 1'b0;
        n_cmp++; if (bus.dup_phase !== 1'b1) begin n_bad++; $display("FAIL pass_dup_phase: got %b want 1", bus.dup_phase); end
        n_cmp++; if (bus.out_instr !== model_dup(add_i)) begin n_bad++; $display("FAIL pass_dup_instr: got %h want %h", bus.out_instr, model_dup(add_i)); end
        tick();
        n_cmp++; if (bus.out_instr !== NOP || bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL pass_done_nop: got %h/%b want %h/1", bus.out_instr, bus.out_valid, NOP); end
        idle();
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.in_instr = 32'h00802283; bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.exec_dup = 1'b1;
        tick();
        bus.in_valid = 1'b0; bus.exec_dup = 1'b0; bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (bus.out_instr !== 32'h04802A83 || bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold: cyc %0d got %h/%b want 04802a83/1", i, bus.out_instr, bus.out_valid); end
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        n_cmp++; if (bus.out_instr !== 32'h04802A83) begin n_bad++; $display("FAIL bp_release: got %h want 04802a83", bus.out_instr); end
        tick();
        n_cmp++; if (bus.out_instr !== NOP) begin n_bad++; $display("FAIL bp_done: got %h want %h", bus.out_instr, NOP); end
        idle();
    endtask

    task automatic test_full();
        logic [31:0] q[$];
        logic [31:0] x;
        do_reset();
        bus.out_ready = 1'b1; bus.in_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            x = rand_instr();
            bus.in_instr = x;
            #1;
            n_cmp++; if (bus.in_ready !== 1'b1 || bus.dup_phase !== 1'b0) begin n_bad++; $display("FAIL full_fill: push %0d got rdy %b ph %b want 1/0", i, bus.in_ready, bus.dup_phase); end
            q.push_back(model_dup(x));
            tick();
        end
        bus.in_instr = rand_instr();
        #1;
        n_cmp++; if (bus.in_ready !== 1'b0 || bus.dup_phase !== 1'b1) begin n_bad++; $display("FAIL full_switch: got rdy %b ph %b want 0/1", bus.in_ready, bus.dup_phase); end
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_instr !== q[i]) begin n_bad++; $display("FAIL full_replay: entry %0d got %h want %h", i, bus.out_instr, q[i]); end
            tick();
        end
        n_cmp++; if (bus.out_instr !== NOP) begin n_bad++; $display("FAIL full_done: got %h want %h", bus.out_instr, NOP); end
        idle();
    endtask

    task automatic test_commits();
        do_reset();
        bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_instr = rand_instr();
        tick();
        bus.in_instr = rand_instr();
        tick();
        bus.in_valid = 1'b0; bus.exec_dup = 1'b1;
        tick();
        bus.exec_dup = 1'b0;
        tick();
        tick();
        n_cmp++; if (bus.out_instr !== NOP) begin n_bad++; $display("FAIL cm_done: got %h want %h", bus.out_instr, NOP); end
        bus.commit_orig = 1'b1;
        tick();
        n_cmp++; if (bus.qed_check !== 1'b0 || bus.err !== 1'b0) begin n_bad++; $display("FAIL cm_step1: got qed %b err %b want 0/0", bus.qed_check, bus.err); end
        bus.commit_dup = 1'b1;
        tick();
        n_cmp++; if (bus.qed_check !== 1'b0 || bus.err !== 1'b0) begin n_bad++; $display("FAIL cm_step2: got qed %b err %b want 0/0", bus.qed_check, bus.err); end
        bus.commit_orig = 1'b0;
        tick();
        n_cmp++; if (bus.qed_check !== 1'b0 || bus.err !== 1'b0) begin n_bad++; $display("FAIL cm_step3: got qed %b err %b want 0/0", bus.qed_check, bus.err); end
        bus.commit_dup = 1'b0;
        tick();
        n_cmp++; if (bus.qed_check !== 1'b1 || bus.err !== 1'b0) begin n_bad++; $display("FAIL cm_qed: got qed %b err %b want 1/0", bus.qed_check, bus.err); end
        tick();
        n_cmp++; if (bus.qed_check !== 1'b1) begin n_bad++; $display("FAIL cm_qed_level: got %b want 1", bus.qed_check); end
        bus.commit_dup = 1'b1;
        tick();
        bus.commit_dup = 1'b0;
        n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL cm_dup_over: got err %b want 1", bus.err); end
        // commit_dup while still in ORIG
        do_reset();
        bus.commit_dup = 1'b1;
        tick();
        bus.commit_dup = 1'b0;
        n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL cm_dup_in_orig: got err %b want 1", bus.err); end
        tick();
        tick();
        n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL cm_err_sticky: got err %b want 1", bus.err); end
        // commit_orig with nothing issued
        do_reset();
        bus.commit_orig = 1'b1;
        tick();
        bus.commit_orig = 1'b0;
        n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL cm_orig_over: got err %b want 1", bus.err); end
        idle();
    endtask

    task automatic test_exec_empty();
        do_reset();
        bus.exec_dup = 1'b1; bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL ee_orig: got vld %b rdy %b want 0/1", bus.out_valid, bus.in_ready); end
            tick();
            n_cmp++; if (bus.dup_phase !== 1'b0) begin n_bad++; $display("FAIL ee_phase: got %b want 0", bus.dup_phase); end
        end
        idle();
    endtask

    task automatic test_mid_reset();
        logic [31:0] x;
        do_reset();
        bus.out_ready = 1'b1; bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin bus.in_instr = rand_instr(); tick(); end
        bus.in_valid = 1'b0; bus.exec_dup = 1'b1; bus.commit_orig = 1'b1;
        tick();
        bus.exec_dup = 1'b0;
        tick();
        bus.commit_orig = 1'b0;
        n_cmp++; if (bus.dup_phase !== 1'b1) begin n_bad++; $display("FAIL mr_in_dup: got %b want 1", bus.dup_phase); end
        rst = 1'b1;
        tick();
        n_cmp++; if (bus.dup_phase !== 1'b0 || bus.out_valid !== 1'b0 || bus.err !== 1'b0) begin n_bad++; $display("FAIL mr_reset: got ph %b vld %b err %b want 0/0/0", bus.dup_phase, bus.out_valid, bus.err); end
        rst = 1'b0; bus.exec_dup = 1'b1;
        tick();
        n_cmp++; if (bus.dup_phase !== 1'b0) begin n_bad++; $display("FAIL mr_fifo_empty: got ph %b want 0", bus.dup_phase); end
        x = rand_instr();
        bus.in_instr = x; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0; bus.exec_dup = 1'b0;
        n_cmp++; if (bus.dup_phase !== 1'b1 || bus.out_instr !== model_dup(x)) begin n_bad++; $display("FAIL mr_replay: got ph %b %h want 1 %h", bus.dup_phase, bus.out_instr, model_dup(x)); end
        tick();
        bus.commit_orig = 1'b1; bus.commit_dup = 1'b1;
        tick();
        bus.commit_orig = 1'b0; bus.commit_dup = 1'b0;
        tick();
        n_cmp++; if (bus.qed_check !== 1'b1 || bus.err !== 1'b0) begin n_bad++; $display("FAIL mr_counters: got qed %b err %b want 1/0", bus.qed_check, bus.err); end
        idle();
    endtask

    task automatic test_random(input int rounds);
        for (int r = 0; r < rounds; r++) begin
            logic [31:0] q[$];
            int  target, n_iss, guard, co, cd;
            logic to_dup, exp_rdy, prev_eq;
            do_reset();
            target = $urandom_range(1, DEPTH + 2);
            n_iss = 0; guard = 0; to_dup = 1'b0;
            while (!to_dup && guard < 300) begin
                bus.in_valid  = ($urandom_range(0, 3) != 0);
                bus.in_instr  = rand_instr();
                bus.out_ready = ($urandom_range(0, 3) != 0);
                bus.exec_dup  = (n_iss >= target);
                #1;
                exp_rdy = bus.out_ready && (q.size() < DEPTH);
                n_cmp++; if (bus.out_instr !== bus.in_instr || bus.out_valid !== bus.in_valid) begin n_bad++; $display("FAIL rnd_pass: rnd %0d got %h/%b want %h/%b", r, bus.out_instr, bus.out_valid, bus.in_instr, bus.in_valid); end
                n_cmp++; if (bus.in_ready !== exp_rdy) begin n_bad++; $display("FAIL rnd_in_ready: rnd %0d got %b want %b", r, bus.in_ready, exp_rdy); end
                if (bus.in_valid && exp_rdy) begin q.push_back(model_dup(bus.in_instr)); n_iss++; end
                to_dup = (bus.exec_dup && q.size() > 0) || (q.size() == DEPTH);
                tick();
                guard++;
                n_cmp++; if (bus.dup_phase !== to_dup) begin n_bad++; $display("FAIL rnd_phase: rnd %0d got %b want %b", r, bus.dup_phase, to_dup); end
            end
            if (!to_dup) begin n_cmp++; n_bad++; $display("FAIL rnd_orig_timeout: rnd %0d got no switch want switch", r); end
            guard = 0;
            while (q.size() > 0 && guard < 300) begin
                bus.out_ready = ($urandom_range(0, 2) != 0);
                bus.in_valid  = ($urandom_range(0, 1) != 0);
                bus.in_instr  = rand_instr();
                bus.exec_dup  = ($urandom_range(0, 1) != 0);
                #1;
                n_cmp++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_instr !== q[0]) begin n_bad++; $display("FAIL rnd_dup: rnd %0d got %h/%b/%b want %h/1/0", r, bus.out_instr, bus.out_valid, bus.in_ready, q[0]); end
                if (bus.out_ready) void'(q.pop_front());
                tick();
                guard++;
            end
            if (q.size() > 0) begin n_cmp++; n_bad++; $display("FAIL rnd_dup_timeout: rnd %0d got %0d left want 0", r, q.size()); end
            idle();
            co = 0; cd = 0;
            while (co < n_iss || cd < n_iss) begin
                bus.commit_orig = (co < n_iss) && ($urandom_range(0, 1) != 0);
                bus.commit_dup  = (cd < co + int'(bus.commit_orig)) && ($urandom_range(0, 1) != 0);
                prev_eq = (co == n_iss) && (cd == n_iss);
                co += int'(bus.commit_orig);
                cd += int'(bus.commit_dup);
                tick();
                n_cmp++; if (bus.qed_check !== prev_eq || bus.out_instr !== NOP) begin n_bad++; $display("FAIL rnd_commit: rnd %0d got qed %b %h want %b %h", r, bus.qed_check, bus.out_instr, prev_eq, NOP); end
            end
            idle();
            tick();
            n_cmp++; if (bus.qed_check !== 1'b1 || bus.err !== 1'b0) begin n_bad++; $display("FAIL rnd_final: rnd %0d got qed %b err %b want 1/0", r, bus.qed_check, bus.err); end
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_passthrough();
        test_backpressure();
        test_full();
        test_commits();
        test_exec_empty();
        test_mid_reset();
        test_random(10);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
